// File: rtl/ps2_scancode_decoder.sv
// rtl/ps2_scancode_decoder.sv - folds PS/2 Set-2 E0/F0 prefixes into key events and queues them in a FWFT FIFO
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter bit FILTER_CTRL    = 1'b1
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic [7:0]                    received_data,
  input  logic                          received_data_en,
  output logic [7:0]                    evt_code,
  output logic                          evt_ext,
  output logic                          evt_break,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clear_overflow,
  output logic [9:0]                    LEDR
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_E0    = 2'd1,
    ST_F0    = 2'd2,
    ST_E0F0  = 2'd3
  } state_e;

  state_e          state_q, state_d, base_state;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [9:0]      evt_d;
  logic            emit;
  logic            is_e0, is_f0, is_ctrl;

  logic [9:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [9:0]      led_q, led_d;
  logic            pop, full, push_ok, ovf_set;

  // Classify the incoming byte
  always_comb begin
    is_e0   = (received_data == 8'hE0);
    is_f0   = (received_data == 8'hF0);
    is_ctrl = (received_data == 8'hAA) || (received_data == 8'hFA) ||
              (received_data == 8'hFE) || (received_data == 8'hEE) ||
              (received_data == 8'h00) || (received_data == 8'hFF);
  end

  // Prefix-folding FSM next state, event formation and prefix timeout
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    emit       = 1'b0;
    evt_d      = '0;
    base_state = state_q;
    if (received_data_en) begin
      tmo_d = '0;
      // A prefix byte after a break prefix abandons it and starts over from IDLE
      if ((state_q == ST_F0 || state_q == ST_E0F0) && (is_e0 || is_f0)) begin
        base_state = ST_IDLE;
      end
      case (base_state)
        ST_IDLE: begin
          state_d = ST_IDLE;
          if (is_e0) begin
            state_d = ST_E0;
          end else if (is_f0) begin
            state_d = ST_F0;
          end else if (!(FILTER_CTRL && is_ctrl)) begin
            emit  = 1'b1;
            evt_d = {2'b00, received_data};
          end
        end
        ST_E0: begin
          if (is_f0) begin
            state_d = ST_E0F0;
          end else if (!is_e0) begin
            emit    = 1'b1;
            evt_d   = {2'b01, received_data};
            state_d = ST_IDLE;
          end
        end
        ST_F0: begin
          emit    = 1'b1;
          evt_d   = {2'b10, received_data};
          state_d = ST_IDLE;
        end
        default: begin
          emit    = 1'b1;
          evt_d   = {2'b11, received_data};
          state_d = ST_IDLE;
        end
      endcase
    end else if (state_q == ST_IDLE) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_LAST) begin
      state_d = ST_IDLE;
      tmo_d   = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // FIFO bookkeeping, sticky overflow and LED mirror next state
  always_comb begin
    pop     = evt_valid && evt_ready;
    full    = (count_q == FULL_CNT);
    push_ok = emit && (!full || pop);
    ovf_set = emit && full && !pop;
    wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
    rd_d    = pop ? rd_q + 1'b1 : rd_q;
    count_d = count_q + CW'(push_ok) - CW'(pop);
    ovf_d   = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (clear_overflow) begin
      ovf_d = 1'b0;
    end
    led_d = emit ? evt_d : led_q;
  end

  // Control state registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tmo_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      led_q   <= led_d;
    end
  end

  // Event storage; contents are only observed through the occupancy-gated head
  always_ff @(posedge CLOCK_50) begin
    if (!reset && push_ok) begin
      mem_q[wr_q] <= evt_d;
    end
  end

  // First-word-fall-through head, forced to zero when the queue is empty
  always_comb begin
    evt_valid = (count_q != '0);
    {evt_break, evt_ext, evt_code} = evt_valid ? mem_q[rd_q] : 10'd0;
    fifo_count = count_q;
    overflow   = ovf_q;
    LEDR       = led_q;
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb/tb_ps2_scancode_decoder.sv - randomized and directed bench for ps2_scancode_decoder
module tb_ps2_scancode_decoder;

  localparam int D = 4;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       en = 1'b0;
  logic       ready = 1'b0;
  logic       clr = 1'b0;

  logic [7:0] code, nf_code;
  logic       ext, brk, valid, ovf, nf_ext, nf_brk, nf_valid, nf_ovf;
  logic [2:0] cnt, nf_cnt;
  logic [9:0] led, nf_led;

  int checks = 0;
  int errors = 0;

  logic [9:0] m_q[$];
  logic       m_ext, m_brk, m_ovf;
  logic [9:0] m_led;
  int         m_idle;

  always #5 clk = ~clk;

  ps2_scancode_decoder #(.FIFO_DEPTH(D), .TIMEOUT_CYCLES(T), .FILTER_CTRL(1'b1)) dut (
    .CLOCK_50(clk), .reset(rst), .received_data(data), .received_data_en(en),
    .evt_code(code), .evt_ext(ext), .evt_break(brk), .evt_valid(valid), .evt_ready(ready),
    .fifo_count(cnt), .overflow(ovf), .clear_overflow(clr), .LEDR(led));

  ps2_scancode_decoder #(.FIFO_DEPTH(D), .TIMEOUT_CYCLES(T), .FILTER_CTRL(1'b0)) dut_nf (
    .CLOCK_50(clk), .reset(rst), .received_data(data), .received_data_en(en),
    .evt_code(nf_code), .evt_ext(nf_ext), .evt_break(nf_brk), .evt_valid(nf_valid), .evt_ready(ready),
    .fifo_count(nf_cnt), .overflow(nf_ovf), .clear_overflow(clr), .LEDR(nf_led));

  wire [24:0] dut_outs = {valid, brk, ext, code, cnt, ovf, led};

  function automatic logic is_ctrl(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) || (b == 8'hEE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  function automatic logic [24:0] model_outs();
    logic [9:0] head;
    head = (m_q.size() != 0) ? m_q[0] : 10'd0;
    return {(m_q.size() != 0), head[9], head[8], head[7:0], 3'(m_q.size()), m_ovf, m_led};
  endfunction

  // Reference: prefixes kept as two pending flags, queue as a SystemVerilog queue
  function automatic void model_step();
    logic       emit, pop, full;
    logic [9:0] ev;
    if (rst) begin
      m_q.delete(); m_ext = 0; m_brk = 0; m_ovf = 0; m_led = 0; m_idle = 0;
      return;
    end
    emit = 0; ev = 0;
    pop  = (m_q.size() != 0) && ready;
    if (en) begin
      m_idle = 0;
      if (data == 8'hE0) begin
        m_ext = 1; m_brk = 0;
      end else if (data == 8'hF0) begin
        if (m_ext && !m_brk) m_brk = 1;
        else begin m_ext = 0; m_brk = 1; end
      end else begin
        if (m_ext || m_brk || !is_ctrl(data)) begin
          emit = 1; ev = {m_brk, m_ext, data};
        end
        m_ext = 0; m_brk = 0;
      end
    end else if (m_ext || m_brk) begin
      m_idle++;
      if (m_idle >= T) begin m_ext = 0; m_brk = 0; m_idle = 0; end
    end
    full = (m_q.size() == D);
    if (pop) void'(m_q.pop_front());
    if (emit) begin
      m_led = ev;
      if (!full || pop) m_q.push_back(ev);
      else m_ovf = 1;
    end
    if (!(emit && full && !pop) && clr) m_ovf = 0;
  endfunction

  task automatic step(input logic e, input logic [7:0] d, input logic r, input logic c);
    en = e; data = d; ready = r; clr = c;
    @(posedge clk);
    model_step();
    #1;
    en = 0; ready = 0; clr = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    step(0, 8'h00, 0, 0);
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_outs !== 25'd0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=%h", dut_outs, 25'd0);
    end
    checks++;
    if ({nf_valid, nf_cnt, nf_ovf, nf_led} !== 15'd0) begin
      errors++; $display("FAIL reset_nf got=%h exp=0", {nf_valid, nf_cnt, nf_ovf, nf_led});
    end
  endtask

  task automatic test_plain_byte();
    do_reset();
    step(1, 8'h1C, 0, 0);
    checks++;
    if ({valid, brk, ext, code, cnt, led} !== {1'b1, 2'b00, 8'h1C, 3'd1, 10'h01C}) begin
      errors++; $display("FAIL plain_1c got=%h exp=%h", {valid, brk, ext, code, cnt, led}, {1'b1, 2'b00, 8'h1C, 3'd1, 10'h01C});
    end
    step(0, 8'h00, 1, 0);
    checks++;
    if ({valid, cnt} !== 4'b0000) begin
      errors++; $display("FAIL plain_pop got=%h exp=0", {valid, cnt});
    end
  endtask

  task automatic test_prefixes();
    do_reset();
    step(1, 8'hE0, 0, 0);
    step(1, 8'hF0, 0, 0);
    checks++;
    if (cnt !== 3'd0) begin
      errors++; $display("FAIL prefix_no_event got=%0d exp=0", cnt);
    end
    step(1, 8'h75, 0, 0);
    checks++;
    if ({cnt, brk, ext, code, led} !== {3'd1, 2'b11, 8'h75, 10'h375}) begin
      errors++; $display("FAIL e0f0_75 got=%h exp=%h", {cnt, brk, ext, code, led}, {3'd1, 2'b11, 8'h75, 10'h375});
    end
    step(0, 8'h00, 1, 0);
    step(1, 8'hF0, 0, 0);
    step(1, 8'h1C, 0, 0);
    checks++;
    if ({cnt, brk, ext, code} !== {3'd1, 2'b10, 8'h1C}) begin
      errors++; $display("FAIL f0_1c got=%h exp=%h", {cnt, brk, ext, code}, {3'd1, 2'b10, 8'h1C});
    end
    step(0, 8'h00, 1, 0);
    step(1, 8'hE0, 0, 0);
    step(1, 8'h74, 0, 0);
    checks++;
    if ({cnt, brk, ext, code} !== {3'd1, 2'b01, 8'h74}) begin
      errors++; $display("FAIL e0_74 got=%h exp=%h", {cnt, brk, ext, code}, {3'd1, 2'b01, 8'h74});
    end
  endtask

  task automatic test_filter();
    do_reset();
    step(1, 8'hAA, 0, 0);
    checks++;
    if ({nf_valid, nf_brk, nf_ext, nf_code} !== {1'b1, 2'b00, 8'hAA}) begin
      errors++; $display("FAIL nofilter_aa got=%h exp=%h", {nf_valid, nf_brk, nf_ext, nf_code}, {1'b1, 2'b00, 8'hAA});
    end
    step(1, 8'hFA, 0, 0);
    checks++;
    if (cnt !== 3'd0) begin
      errors++; $display("FAIL filter_aa_fa got=%0d exp=0", cnt);
    end
    step(1, 8'hE0, 0, 0);
    step(1, 8'hAA, 0, 0);
    checks++;
    if ({valid, brk, ext, code} !== {1'b1, 2'b01, 8'hAA}) begin
      errors++; $display("FAIL filter_e0_aa got=%h exp=%h", {valid, brk, ext, code}, {1'b1, 2'b01, 8'hAA});
    end
  endtask

  task automatic test_timeout();
    do_reset();
    step(1, 8'hE0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 8'h00, 0, 0);
    step(1, 8'h1C, 0, 0);
    checks++;
    if ({cnt, brk, ext, code} !== {3'd1, 2'b00, 8'h1C}) begin
      errors++; $display("FAIL timeout_drop got=%h exp=%h", {cnt, brk, ext, code}, {3'd1, 2'b00, 8'h1C});
    end
    step(0, 8'h00, 1, 0);
    step(1, 8'hE0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 8'h00, 0, 0);
    step(1, 8'h1C, 0, 0);
    checks++;
    if ({cnt, brk, ext, code} !== {3'd1, 2'b01, 8'h1C}) begin
      errors++; $display("FAIL timeout_keep got=%h exp=%h", {cnt, brk, ext, code}, {3'd1, 2'b01, 8'h1C});
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 8'h1C + 8'(i), 0, 0);
    checks++;
    if ({cnt, ovf, code, led} !== {3'd4, 1'b1, 8'h1C, 10'h020}) begin
      errors++; $display("FAIL overflow_fill got=%h exp=%h", {cnt, ovf, code, led}, {3'd4, 1'b1, 8'h1C, 10'h020});
    end
    step(1, 8'h21, 1, 0);
    checks++;
    if ({cnt, code} !== {3'd4, 8'h1D}) begin
      errors++; $display("FAIL overflow_pushpop got=%h exp=%h", {cnt, code}, {3'd4, 8'h1D});
    end
    step(0, 8'h00, 0, 1);
    checks++;
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL overflow_clear got=%b exp=0", ovf);
    end
    step(1, 8'h22, 0, 1);
    checks++;
    if ({ovf, cnt} !== {1'b1, 3'd4}) begin
      errors++; $display("FAIL overflow_set_wins got=%h exp=%h", {ovf, cnt}, {1'b1, 3'd4});
    end
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    checks++;
    if ({valid, cnt, code} !== {1'b0, 3'd0, 8'h00}) begin
      errors++; $display("FAIL pop_empty got=%h exp=0", {valid, cnt, code});
    end
  endtask

  task automatic test_reset_midprefix();
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 8'h30 + 8'(i), 0, 0);
    step(1, 8'hE0, 0, 0);
    step(1, 8'hF0, 0, 0);
    rst = 1;
    step(1, 8'h1C, 1, 0);
    rst = 0;
    checks++;
    if ({cnt, valid, led, ovf} !== 15'd0) begin
      errors++; $display("FAIL reset_mid got=%h exp=0", {cnt, valid, led, ovf});
    end
    step(1, 8'h1C, 0, 0);
    checks++;
    if ({cnt, brk, ext, code} !== {3'd1, 2'b00, 8'h1C}) begin
      errors++; $display("FAIL reset_then_1c got=%h exp=%h", {cnt, brk, ext, code}, {3'd1, 2'b00, 8'h1C});
    end
  endtask

  task automatic test_random();
    logic [7:0] ctrl_list [6];
    logic [7:0] b;
    int gap, sel;
    ctrl_list[0] = 8'hAA; ctrl_list[1] = 8'hFA; ctrl_list[2] = 8'hFE;
    ctrl_list[3] = 8'hEE; ctrl_list[4] = 8'h00; ctrl_list[5] = 8'hFF;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 8'hE0;
      else if (sel == 1) b = 8'hF0;
      else if (sel == 2) b = ctrl_list[$urandom_range(0, 5)];
      else b = 8'($urandom);
      step(1, b, ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
      checks++;
      if (dut_outs !== model_outs()) begin
        errors++; $display("FAIL random_byte n=%0d got=%h exp=%h", n, dut_outs, model_outs());
      end
      gap = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 24) : $urandom_range(0, 10);
      for (int g = 0; g < gap; g++) begin
        step(0, 8'h00, ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
        checks++;
        if (dut_outs !== model_outs()) begin
          errors++; $display("FAIL random_idle n=%0d got=%h exp=%h", n, dut_outs, model_outs());
        end
      end
    end
  endtask

  initial begin
    m_ext = 0; m_brk = 0; m_ovf = 0; m_led = 0; m_idle = 0;
    #2;
    test_reset();
    test_plain_byte();
    test_prefixes();
    test_filter();
    test_timeout();
    test_overflow();
    test_reset_midprefix();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
